usb_link_controller: RTL and testbench
======================================

USB_LINK_CONTROLLER -- requirements
Module: usb_link_controller

Interface
REQ-001 Parameter TURN_CYC, default 2, meaning bus turnaround length in Clk cycles (1..15).
REQ-002 Parameter RESP_TO, default 16, meaning response-wait timeout in Clk cycles (1..255).
REQ-003 Parameter MAX_ERR, default 3, meaning consecutive receive errors that declare link fault (1..15).
REQ-004 Clk  input  1  single system clock; all state changes on posedge Clk.
REQ-005 Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-006 Tx_Req  input  1  level request to transmit a packet; held high until Tx_Start is seen.
REQ-007 Tx_Done  input  1  transmitter finished EOP; sampled only in TX_BUSY.
REQ-008 Rx_Sync  input  1  receiver sync-detected flag.
REQ-009 Rx_EOP  input  1  receiver end-of-packet flag.
REQ-010 Rx_Error  input  1  receiver bit-stuff error flag.
REQ-011 Dir  output  1  bus direction; 1 = transmitter drives D+/D-, 0 = receive.
REQ-012 Tx_Ready  output  1  receiver inhibit; 0 permits receiver sync hunt.
REQ-013 Tx_Start  output  1  one-cycle pulse launching the transmitter.
REQ-014 Rx_Arm  output  1  one-cycle pulse re-arming the receiver (drives its Active input).
REQ-015 Timeout  output  1  one-cycle pulse on response-wait expiry.
REQ-016 Link_Fault  output  1  sticky fault flag.
REQ-017 Err_Count  output  4  total receive errors since reset, saturating at 15.

Function
REQ-018 States SHALL be IDLE, TX_TURN, TX_BUSY, RX_TURN, RESP_WAIT, RX_DATA, ERR_HOLD.
REQ-019 Per state: IDLE Dir=0 Tx_Ready=0; TX_TURN/TX_BUSY Dir=1 Tx_Ready=1; RX_TURN Dir=0 Tx_Ready=1; RESP_WAIT/RX_DATA Dir=0 Tx_Ready=0; ERR_HOLD Dir=0 Tx_Ready=1.
REQ-020 IDLE: Rx_Sync=1 -> RX_DATA; else Tx_Req=1 and Link_Fault=0 -> TX_TURN; Rx_Sync and Tx_Req together -> Rx_Sync wins, Tx_Req stays pending.
REQ-021 TX_TURN SHALL last exactly TURN_CYC cycles, then -> TX_BUSY with Tx_Start=1 on the first TX_BUSY cycle only.
REQ-022 TX_BUSY: Tx_Done=1 -> RX_TURN; no timeout in TX_BUSY.
REQ-023 RX_TURN SHALL last exactly TURN_CYC cycles, then -> RESP_WAIT with Rx_Arm=1 on the first RESP_WAIT cycle.
REQ-024 RESP_WAIT: Rx_Sync=1 -> RX_DATA; after RESP_TO cycles without Rx_Sync -> IDLE with Timeout=1 for one cycle; Rx_Sync on the expiry cycle wins over timeout.
REQ-025 RX_DATA: Rx_Error=1 -> ERR_HOLD; else Rx_EOP=1 -> IDLE with Rx_Arm=1 one cycle and consecutive-error counter cleared; Rx_Error and Rx_EOP together -> error wins.
REQ-026 ERR_HOLD SHALL last one cycle: Err_Count += 1 (saturate 15), consecutive counter += 1 (saturate MAX_ERR), then -> IDLE with Rx_Arm=1.
REQ-027 Link_Fault SHALL set on the cycle the consecutive counter reaches MAX_ERR and clear only on reset; while set, Tx_Req SHALL be ignored, receive path stays operational.
REQ-028 Turnaround and timeout SHALL share one 8-bit down-counter, loaded on state entry.
REQ-029 Rx_Sync/Rx_EOP/Rx_Error outside the states naming them SHALL be ignored; Tx_Done outside TX_BUSY SHALL be ignored.
REQ-030 All outputs SHALL be registered; Tx_Start, Rx_Arm, Timeout never high more than one consecutive cycle.

Reset
REQ-031 Reset=0 SHALL asynchronously force IDLE, Dir=0, Tx_Ready=0, Tx_Start=0, Rx_Arm=0, Timeout=0, Link_Fault=0, Err_Count=0, counters=0.
REQ-032 Reset asserted mid-transmit SHALL drop Dir to 0 without waiting for Clk; first state after release is IDLE.

Verification
REQ-033 Tx_Req=1 in IDLE, defaults -> Dir=1 next cycle, Tx_Start pulse 3 cycles after request sampled, Tx_Ready=1 throughout.
REQ-034 Tx_Done in TX_BUSY, no Rx_Sync -> Dir=0 after 2 cycles, Rx_Arm pulse, Timeout pulse exactly 16 cycles into RESP_WAIT, return to IDLE.
REQ-035 Rx_Sync and Tx_Req same cycle in IDLE -> RX_DATA, Dir stays 0; after Rx_EOP, Rx_Arm pulse, then TX_TURN entered.
REQ-036 Three packets each ending Rx_Error (with Rx_EOP same cycle on one) -> Err_Count=3, Link_Fault=1, subsequent Tx_Req produces no Tx_Start.
REQ-037 Two errors, one good EOP, two errors -> Err_Count=4, Link_Fault=0; 16 further errors -> Err_Count holds 15.
REQ-038 Reset pulsed low during TX_BUSY -> Dir=0 and Err_Count=0 immediately, no Tx_Start after release until new Tx_Req.

Source files
------------

// File: rtl/usb_link_controller.sv
// USB link-layer controller: sequences bus direction, turnaround, response wait
// and receive-error tracking around a transmitter/receiver pair.
module usb_link_controller #(
  parameter int TURN_CYC = 2,
  parameter int RESP_TO  = 16,
  parameter int MAX_ERR  = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tx_Req,
  input  logic       Tx_Done,
  input  logic       Rx_Sync,
  input  logic       Rx_EOP,
  input  logic       Rx_Error,
  output logic       Dir,
  output logic       Tx_Ready,
  output logic       Tx_Start,
  output logic       Rx_Arm,
  output logic       Timeout,
  output logic       Link_Fault,
  output logic [3:0] Err_Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_TURN,
    S_TX_BUSY,
    S_RX_TURN,
    S_RESP_WAIT,
    S_RX_DATA,
    S_ERR_HOLD
  } state_t;

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);
  localparam logic [7:0] RESP_LOAD = 8'(RESP_TO - 1);
  localparam logic [3:0] MAX_ERR_L = 4'(MAX_ERR);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt;
  logic [3:0] r_consec, w_consec;
  logic [3:0] r_err_cnt, w_err_cnt;
  logic       r_fault, w_fault;
  logic       w_tx_start, w_rx_arm, w_timeout, w_dir, w_tx_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_consec  <= 4'd0;
      r_err_cnt <= 4'd0;
      r_fault   <= 1'b0;
      Dir       <= 1'b0;
      Tx_Ready  <= 1'b0;
      Tx_Start  <= 1'b0;
      Rx_Arm    <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_consec  <= w_consec;
      r_err_cnt <= w_err_cnt;
      r_fault   <= w_fault;
      Dir       <= w_dir;
      Tx_Ready  <= w_tx_ready;
      Tx_Start  <= w_tx_start;
      Rx_Arm    <= w_rx_arm;
      Timeout   <= w_timeout;
    end
  end

  // Pulses and bus-direction levels are computed against the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    w_next     = r_state;
    w_cnt      = r_cnt;
    w_consec   = r_consec;
    w_err_cnt  = r_err_cnt;
    w_fault    = r_fault;
    w_tx_start = 1'b0;
    w_rx_arm   = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Rx_Sync) begin
          w_next = S_RX_DATA;
        end else if (Tx_Req && !r_fault) begin
          w_next = S_TX_TURN;
          w_cnt  = TURN_LOAD;
        end
      end
      S_TX_TURN: begin
        if (r_cnt == 8'd0) begin
          w_next     = S_TX_BUSY;
          w_tx_start = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_TX_BUSY: begin
        if (Tx_Done) begin
          w_next = S_RX_TURN;
          w_cnt  = TURN_LOAD;
        end
      end
      S_RX_TURN: begin
        if (r_cnt == 8'd0) begin
          w_next   = S_RESP_WAIT;
          w_cnt    = RESP_LOAD;
          w_rx_arm = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_RESP_WAIT: begin
        if (Rx_Sync) begin
          w_next = S_RX_DATA;
        end else if (r_cnt == 8'd0) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_RX_DATA: begin
        if (Rx_Error) begin
          w_next = S_ERR_HOLD;
        end else if (Rx_EOP) begin
          w_next   = S_IDLE;
          w_rx_arm = 1'b1;
          w_consec = 4'd0;
        end
      end
      S_ERR_HOLD: begin
        w_next   = S_IDLE;
        w_rx_arm = 1'b1;
        if (r_err_cnt != 4'd15) w_err_cnt = r_err_cnt + 4'd1;
        if (r_consec < MAX_ERR_L) w_consec = r_consec + 4'd1;
        if (w_consec == MAX_ERR_L) w_fault = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_dir      = 1'b0;
    w_tx_ready = 1'b0;
    case (w_next)
      S_TX_TURN, S_TX_BUSY:  begin w_dir = 1'b1; w_tx_ready = 1'b1; end
      S_RX_TURN, S_ERR_HOLD: w_tx_ready = 1'b1;
      default:               ;
    endcase
  end

  assign Link_Fault = r_fault;
  assign Err_Count  = r_err_cnt;

endmodule

// File: tb/tb_usb_link_controller.sv
// Directed bench for usb_link_controller: vector table plus hand-written
// sequences for timeout, async reset, error counting and saturation.
module tb_usb_link_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Tx_Req = 1'b0, Tx_Done = 1'b0, Rx_Sync = 1'b0, Rx_EOP = 1'b0, Rx_Error = 1'b0;
  logic       Dir, Tx_Ready, Tx_Start, Rx_Arm, Timeout, Link_Fault;
  logic [3:0] Err_Count;

  int n_checks = 0;
  int n_pass   = 0;

  usb_link_controller #(.TURN_CYC(2), .RESP_TO(16), .MAX_ERR(3)) dut (
    .Clk(Clk), .Reset(Reset), .Tx_Req(Tx_Req), .Tx_Done(Tx_Done),
    .Rx_Sync(Rx_Sync), .Rx_EOP(Rx_EOP), .Rx_Error(Rx_Error),
    .Dir(Dir), .Tx_Ready(Tx_Ready), .Tx_Start(Tx_Start), .Rx_Arm(Rx_Arm),
    .Timeout(Timeout), .Link_Fault(Link_Fault), .Err_Count(Err_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] in;   // {req, done, sync, eop, err}
    logic [5:0] out;  // {dir, tx_ready, tx_start, rx_arm, timeout, fault}
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[32];

  function automatic vec_t mk(logic [4:0] in, logic [5:0] out, logic [3:0] ec);
    vec_t v;
    v.in = in; v.out = out; v.ec = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(logic [4:0] in);
    @(negedge Clk);
    {Tx_Req, Tx_Done, Rx_Sync, Rx_EOP, Rx_Error} = in;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    {Tx_Req, Tx_Done, Rx_Sync, Rx_EOP, Rx_Error} = 5'b0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic err_pkt();
    step(5'b00100);
    step(5'b00001);
    step(5'b00000);
  endtask

  task automatic good_pkt();
    step(5'b00100);
    step(5'b00010);
  endtask

  // Drive a full transmit and turnaround, ending on the first RESP_WAIT cycle.
  task automatic to_resp_wait();
    step(5'b10000);
    step(5'b10000);
    step(5'b10000);
    check("tx_start_before_resp", 32'(Tx_Start), 32'd1);
    step(5'b01000);
    step(5'b00000);
    step(5'b00000);
    check("rx_arm_resp_entry", 32'(Rx_Arm), 32'd1);
  endtask

  initial begin
    tbl[0]  = mk(5'b10000, 6'b110000, 4'd0);
    tbl[1]  = mk(5'b10000, 6'b110000, 4'd0);
    tbl[2]  = mk(5'b10000, 6'b111000, 4'd0);
    tbl[3]  = mk(5'b00000, 6'b110000, 4'd0);
    tbl[4]  = mk(5'b00110, 6'b110000, 4'd0);
    tbl[5]  = mk(5'b01000, 6'b010000, 4'd0);
    tbl[6]  = mk(5'b00000, 6'b010000, 4'd0);
    tbl[7]  = mk(5'b00000, 6'b000100, 4'd0);
    tbl[8]  = mk(5'b00100, 6'b000000, 4'd0);
    tbl[9]  = mk(5'b00010, 6'b000100, 4'd0);
    tbl[10] = mk(5'b10100, 6'b000000, 4'd0);
    tbl[11] = mk(5'b10010, 6'b000100, 4'd0);
    tbl[12] = mk(5'b10000, 6'b110000, 4'd0);
    tbl[13] = mk(5'b10000, 6'b110000, 4'd0);
    tbl[14] = mk(5'b10000, 6'b111000, 4'd0);
    tbl[15] = mk(5'b01000, 6'b010000, 4'd0);
    tbl[16] = mk(5'b00000, 6'b010000, 4'd0);
    tbl[17] = mk(5'b00000, 6'b000100, 4'd0);
    tbl[18] = mk(5'b00100, 6'b000000, 4'd0);
    tbl[19] = mk(5'b00011, 6'b010000, 4'd0);
    tbl[20] = mk(5'b00000, 6'b000100, 4'd1);
    tbl[21] = mk(5'b00100, 6'b000000, 4'd1);
    tbl[22] = mk(5'b00001, 6'b010000, 4'd1);
    tbl[23] = mk(5'b00000, 6'b000100, 4'd2);
    tbl[24] = mk(5'b00010, 6'b000000, 4'd2);
    tbl[25] = mk(5'b00100, 6'b000000, 4'd2);
    tbl[26] = mk(5'b00001, 6'b010000, 4'd2);
    tbl[27] = mk(5'b00000, 6'b000101, 4'd3);
    tbl[28] = mk(5'b10000, 6'b000001, 4'd3);
    tbl[29] = mk(5'b10000, 6'b000001, 4'd3);
    tbl[30] = mk(5'b00100, 6'b000001, 4'd3);
    tbl[31] = mk(5'b00010, 6'b000101, 4'd3);

    Reset = 1'b0;
    #12;
    check("reset_outputs",
          32'({Dir, Tx_Ready, Tx_Start, Rx_Arm, Timeout, Link_Fault, Err_Count}), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i),
            32'({Dir, Tx_Ready, Tx_Start, Rx_Arm, Timeout, Link_Fault, Err_Count}),
            32'({tbl[i].out, tbl[i].ec}));
    end

    // Non-consecutive errors: a good packet clears the consecutive count.
    do_reset();
    err_pkt();
    err_pkt();
    good_pkt();
    err_pkt();
    err_pkt();
    check("ec_after_2_good_2", 32'(Err_Count), 32'd4);
    check("no_fault_after_2_good_2", 32'(Link_Fault), 32'd0);

    // Async reset during TX_BUSY with a nonzero error count.
    step(5'b10000);
    step(5'b10000);
    step(5'b10000);
    step(5'b00000);
    check("in_tx_busy_dir", 32'(Dir), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_dir", 32'(Dir), 32'd0);
    check("async_reset_ec", 32'(Err_Count), 32'd0);
    check("async_reset_txready", 32'(Tx_Ready), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(5'b00000);
      check($sformatf("post_reset_idle%0d", i), 32'({Dir, Tx_Start, Tx_Ready}), 32'd0);
    end

    // Error count saturates at 15; fault latches at the third error.
    for (int i = 0; i < 16; i++) begin
      err_pkt();
      check($sformatf("sat_ec%0d", i), 32'(Err_Count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      check($sformatf("sat_fault%0d", i), 32'(Link_Fault), (i >= 2) ? 32'd1 : 32'd0);
    end

    // Response timeout: pulse lands 16 cycles after RESP_WAIT entry.
    do_reset();
    to_resp_wait();
    for (int i = 1; i < 16; i++) begin
      step(5'b00000);
      check($sformatf("resp_wait%0d", i), 32'({Timeout, Dir, Tx_Ready}), 32'd0);
    end
    step(5'b00000);
    check("timeout_pulse", 32'(Timeout), 32'd1);
    step(5'b00000);
    check("timeout_one_cycle", 32'(Timeout), 32'd0);
    check("idle_after_timeout_dir", 32'(Dir), 32'd0);

    // Rx_Sync on the expiry cycle beats the timeout.
    to_resp_wait();
    for (int i = 1; i < 16; i++) step(5'b00000);
    step(5'b00100);
    check("sync_beats_timeout", 32'({Timeout, Tx_Ready, Dir}), 32'd0);
    step(5'b00010);
    check("eop_rearm_after_sync", 32'(Rx_Arm), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
